// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped, one-word-per-block instruction cache
// Zero-cycle hits; misses fill from the memory controller through a latched miss address.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, next_state;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  logic [29:0]      miss_addr;
  logic             miss_latch;
  logic             fill_we;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             tag_hit;
  logic             unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_addr[IDX_W-1:0];
  assign fill_tag      = miss_addr[29:IDX_W];
  assign tag_hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_offset = ^imemaddr[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    fill_we    = 1'b0;
    miss_latch = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (tag_hit) begin
            ihit     = 1'b1;
            imemload = data_mem[req_idx];
          end else begin
            miss_latch = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        // The fill always targets the latched address, whatever the datapath does meanwhile.
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        if (!iwait) begin
          fill_we    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr <= 30'h0;
    end else if (miss_latch) begin
      miss_addr <= imemaddr[31:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (fill_we) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data are only observable through valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - table-driven self-checking bench for icache_direct
// Each row drives one clock cycle and checks the outputs mid-cycle.
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_checks;
  int n_fail;

  icache_direct #(.SETS(16), .IDX_W(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst_n;
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] load;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic ren, input logic [31:0] addr,
                              input logic iw, input logic [31:0] load, input logic e_hit,
                              input logic [31:0] e_load, input logic e_iren,
                              input logic [31:0] e_iaddr);
    vec_t v;
    v.rst_n   = rst_n;
    v.ren     = ren;
    v.addr    = addr;
    v.iw      = iw;
    v.load    = load;
    v.e_hit   = e_hit;
    v.e_load  = e_load;
    v.e_iren  = e_iren;
    v.e_iaddr = e_iaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_hit, input logic [31:0] e_load,
                           input logic e_iren, input logic [31:0] e_iaddr);
    check({tag, " ihit"},     {31'h0, ihit}, {31'h0, e_hit});
    check({tag, " imemload"}, imemload,      e_load);
    check({tag, " iREN"},     {31'h0, iREN}, {31'h0, e_iren});
    check({tag, " iaddr"},    iaddr,         e_iaddr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;

    //                rst ren addr          iw  iload          hit load          iren iaddr
    vecs.push_back(mk(0, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 0 reset
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 1 cold miss
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040));  // 2 fill wait
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040));  // 3
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040));  // 4
    vecs.push_back(mk(1, 1, 32'h0000_0040, 0, 32'h8C22_0004, 0, 32'h0,         1, 32'h0000_0040));  // 5 fill done
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));          // 6 hit
    vecs.push_back(mk(1, 1, 32'h0000_0043, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));          // 7 byte offset
    vecs.push_back(mk(1, 0, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 8 no request
    vecs.push_back(mk(1, 1, 32'h0000_0080, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 9 conflict miss
    vecs.push_back(mk(1, 1, 32'h0000_0080, 0, 32'h1111_1111, 0, 32'h0,         1, 32'h0000_0080));  // 10
    vecs.push_back(mk(1, 1, 32'h0000_0080, 1, 32'h0,         1, 32'h1111_1111, 0, 32'h0));          // 11
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 12 evicted
    vecs.push_back(mk(1, 1, 32'h0000_0040, 0, 32'h8C22_0004, 0, 32'h0,         1, 32'h0000_0040));  // 13
    vecs.push_back(mk(1, 1, 32'h0000_0040, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));          // 14
    vecs.push_back(mk(1, 1, 32'h0000_0100, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 15 miss 0x100
    vecs.push_back(mk(1, 1, 32'h0000_0104, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0100));  // 16 addr moves
    vecs.push_back(mk(1, 0, 32'h0000_0104, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0100));  // 17 ren drops
    vecs.push_back(mk(1, 1, 32'h0000_0104, 0, 32'h2222_2222, 0, 32'h0,         1, 32'h0000_0100));  // 18
    vecs.push_back(mk(1, 1, 32'h0000_0104, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 19 0x104 misses
    vecs.push_back(mk(1, 1, 32'h0000_0104, 0, 32'h3333_3333, 0, 32'h0,         1, 32'h0000_0104));  // 20
    vecs.push_back(mk(1, 1, 32'h0000_0104, 1, 32'h0,         1, 32'h3333_3333, 0, 32'h0));          // 21
    vecs.push_back(mk(1, 1, 32'h0000_0100, 1, 32'h0,         1, 32'h2222_2222, 0, 32'h0));          // 22
    vecs.push_back(mk(1, 1, 32'h0000_0200, 1, 32'h0,         0, 32'h0,         0, 32'h0));          // 23 miss 0x200
    vecs.push_back(mk(1, 1, 32'h0000_0200, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0200));  // 24 FILL

    @(posedge CLK);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      nRST     = vecs[i].rst_n;
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      iwait    = vecs[i].iw;
      iload    = vecs[i].load;
      #4;
      check_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load, vecs[i].e_iren,
                vecs[i].e_iaddr);
      @(posedge CLK);
      #1;
    end

    // Reset mid-fill on 0x200: outputs must drop without waiting for a clock edge.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0200;
    iwait    = 1'b1;
    #1;
    check("pre-reset iREN", {31'h0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    check_all("async reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #4;
    check_all("post-reset miss", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    #4;
    check_all("refill 0x200", 1'b0, 32'h0, 1'b1, 32'h0000_0200);
    iwait = 1'b0;
    iload = 32'h4444_4444;
    @(posedge CLK);
    #1;
    iwait = 1'b1;
    iload = 32'h0;
    #4;
    check_all("hit 0x200", 1'b1, 32'h4444_4444, 1'b0, 32'h0);

    // Valid bits were cleared by the reset, so a previously filled index misses.
    imemaddr = 32'h0000_0104;
    #1;
    check_all("0x104 after reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    #4;
    check_all("0x104 refill", 1'b0, 32'h0, 1'b1, 32'h0000_0104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
